wb_commit: RTL and testbench
============================

WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2: number of cycles after a flush during which incoming instructions are discarded (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port ms_valid, input, 1 bit: MEM stage holds an instruction.
REQ-005 The block SHALL have port ws_allowin, output, 1 bit: WB accepts an instruction this cycle.
REQ-006 The block SHALL have ports ms_pc (input, 32), ms_vaddr (input, 32), ms_rf_we (input, 1), ms_rf_waddr (input, 5) and ms_rf_wdata (input, 32): instruction payload.
REQ-007 The block SHALL have ports ms_ex_adef, ms_ex_ine, ms_ex_sys, ms_ex_brk, ms_ex_ale and ms_ertn, each input, 1 bit: per-instruction exception and ertn flags.
REQ-008 The block SHALL have ports ms_csr_we (input, 1), ms_csr_num (input, 14), ms_csr_wmask (input, 32) and ms_csr_wvalue (input, 32): CSR write request.
REQ-009 The block SHALL have ports has_int (input, 1), csr_eentry (input, 32) and csr_era (input, 32): driven by the CSR file.
REQ-010 The block SHALL have ports wb_ex (output, 1), wb_ecode (output, 6), wb_esubcode (output, 9), wb_pc (output, 32), wb_vaddr (output, 32) and ertn_flush (output, 1): exception commit to the CSR file.
REQ-011 The block SHALL have ports csr_we (output, 1), csr_num (output, 14), csr_wmask (output, 32) and csr_wvalue (output, 32): CSR write to the CSR file.
REQ-012 The block SHALL have ports rf_we (output, 1), rf_waddr (output, 5) and rf_wdata (output, 32): register file write.
REQ-013 The block SHALL have ports flush_req (output, 1) and flush_target (output, 32): pipeline redirect.

Function
REQ-014 The block SHALL register the MEM payload into the WB register when ms_valid && ws_allowin; ws_valid <= ms_valid && ws_allowin && state==RUN.
REQ-015 ws_allowin SHALL be 1 in every state; instructions accepted in FLUSH are discarded and do not set ws_valid.
REQ-016 Exception priority SHALL be: has_int (ecode 0x0), adef (0x8, sub 0), ine (0xD), sys (0xB), brk (0xC), ale (0x9); wb_esubcode is 0 for all of these.
REQ-017 has_int SHALL be sampled combinationally only while ws_valid; the interrupt attaches to the WB instruction and that instruction does not commit.
REQ-018 wb_ex SHALL equal ws_valid && any exception; wb_pc is ws_pc; wb_vaddr is ws_vaddr.
REQ-019 ertn_flush SHALL equal ws_valid && ws_ertn && !wb_ex, so an exception overrides ertn.
REQ-020 rf_we and csr_we SHALL be gated by ws_valid && !wb_ex.
REQ-021 flush_req SHALL equal wb_ex || ertn_flush; flush_target is csr_eentry on wb_ex and csr_era on ertn_flush.
REQ-022 All outputs SHALL be combinational from the WB register; every commit output lasts exactly one cycle, because ws_valid clears the next cycle unless a new instruction is accepted.
REQ-023 The FSM SHALL have states RUN and FLUSH; RUN moves to FLUSH on flush_req and loads a 3-bit counter with FLUSH_CYCLES.
REQ-024 In FLUSH the counter SHALL decrement each cycle; the FSM returns to RUN on the cycle the counter reaches 1.
REQ-025 An instruction presented on the same cycle as flush_req SHALL be discarded.
REQ-026 A flush_req cannot occur in FLUSH; an ms_ertn or ms exception arriving in FLUSH SHALL be dropped with no effect.

Reset
REQ-027 Asserting resetn low SHALL asynchronously set ws_valid=0, state=RUN and counter=0, so every commit output is 0 and ws_allowin=1.
REQ-028 A reset during FLUSH SHALL abort the flush; the first instruction after deassertion is accepted.
REQ-029 Payload registers SHALL NOT require reset.

Configuration
REQ-030 With macro WB_DEBUG_TRACE_EN defined, the block SHALL add outputs debug_wb_pc (32), debug_wb_rf_we (4), debug_wb_rf_wnum (5) and debug_wb_rf_wdata (32).
REQ-031 With WB_DEBUG_TRACE_EN defined, debug_wb_rf_we SHALL be {4{rf_we}}, debug_wb_pc SHALL be ws_pc, and all trace outputs are 0 in reset.
REQ-032 Without WB_DEBUG_TRACE_EN, the trace ports and their logic SHALL be absent.

Structure
REQ-033 Package wb_pkg SHALL hold the ECODE_INT/ADEF/ALE/SYS/BRK/INE constants, the FSM state enum and the WB payload struct.
REQ-034 A sub-module wb_ex_prio (combinational priority encoder: flags plus has_int in, valid/ecode/esubcode out) SHALL be instantiated once.

Verification
REQ-035 Bench SHALL cover: ms_pc=0x1c000010, rf_we=1, waddr=5, wdata=0x1234, no exceptions -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_ex=0.
REQ-036 Bench SHALL cover: ms_ex_sys=1 and ms_ex_ale=1, csr_eentry=0x1c008000 -> wb_ecode=0xB, rf_we=0, flush_req=1, flush_target=0x1c008000.
REQ-037 Bench SHALL cover: has_int=1 with a WB instruction carrying ms_ex_brk=1 -> wb_ecode=0x0, wb_pc equals the instruction pc.
REQ-038 Bench SHALL cover: ms_ertn=1, csr_era=0x1c000100 -> ertn_flush=1, flush_target=0x1c000100; the next 2 valid MEM instructions (FLUSH_CYCLES=2) produce no rf_we; the third commits.
REQ-039 Bench SHALL cover: ms_ertn=1 together with ms_ex_ine=1 -> wb_ex=1, ecode=0xD, ertn_flush=0.
REQ-040 Bench SHALL cover: resetn low one cycle into FLUSH -> all outputs 0; after release, the first valid instruction commits.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back commit stage.
package wb_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;

    typedef enum logic {
        RUN,
        FLUSH
    } wb_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        ex_adef;
        logic        ex_ine;
        logic        ex_sys;
        logic        ex_brk;
        logic        ex_ale;
        logic        ertn;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
    } wb_payload_t;

endpackage

// File: rtl/wb_ex_prio.sv
// Exception priority encoder for the instruction held in WB.
module wb_ex_prio
    import wb_pkg::*;
(
    input  logic       has_int,
    input  logic       ex_adef,
    input  logic       ex_ine,
    input  logic       ex_sys,
    input  logic       ex_brk,
    input  logic       ex_ale,
    output logic       ex_valid,
    output logic [5:0] ecode,
    output logic [8:0] esubcode
);

    assign esubcode = '0;

    always_comb begin
        ex_valid = 1'b1;
        ecode    = '0;
        if (has_int)      ecode = ECODE_INT;
        else if (ex_adef) ecode = ECODE_ADEF;
        else if (ex_ine)  ecode = ECODE_INE;
        else if (ex_sys)  ecode = ECODE_SYS;
        else if (ex_brk)  ecode = ECODE_BRK;
        else if (ex_ale)  ecode = ECODE_ALE;
        else              ex_valid = 1'b0;
    end

endmodule

// File: rtl/wb_commit.sv
// Write-back commit stage: exceptions, ertn, CSR/RF writes, flush window.
// Optional debug trace ports enabled by WB_DEBUG_TRACE_EN.
module wb_commit
    import wb_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_vaddr,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_rf_waddr,
    input  logic [31:0] ms_rf_wdata,
    input  logic        ms_ex_adef,
    input  logic        ms_ex_ine,
    input  logic        ms_ex_sys,
    input  logic        ms_ex_brk,
    input  logic        ms_ex_ale,
    input  logic        ms_ertn,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wvalue,
    input  logic        has_int,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        ertn_flush,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush_req,
    output logic [31:0] flush_target
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    localparam logic [2:0] FLUSH_LOAD = FLUSH_CYCLES[2:0];

    wb_payload_t ms_pl;
    wb_payload_t ws;
    logic        ws_valid;
    logic        accept;
    logic        commit;
    wb_state_t   state;
    wb_state_t   state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic        ex_valid;
    logic [5:0]  ex_code;
    logic [8:0]  ex_sub;

    assign ws_allowin = 1'b1;
    assign accept     = ms_valid & ws_allowin;

    always_comb begin
        ms_pl            = '0;
        ms_pl.pc         = ms_pc;
        ms_pl.vaddr      = ms_vaddr;
        ms_pl.rf_we      = ms_rf_we;
        ms_pl.rf_waddr   = ms_rf_waddr;
        ms_pl.rf_wdata   = ms_rf_wdata;
        ms_pl.ex_adef    = ms_ex_adef;
        ms_pl.ex_ine     = ms_ex_ine;
        ms_pl.ex_sys     = ms_ex_sys;
        ms_pl.ex_brk     = ms_ex_brk;
        ms_pl.ex_ale     = ms_ex_ale;
        ms_pl.ertn       = ms_ertn;
        ms_pl.csr_we     = ms_csr_we;
        ms_pl.csr_num    = ms_csr_num;
        ms_pl.csr_wmask  = ms_csr_wmask;
        ms_pl.csr_wvalue = ms_csr_wvalue;
    end

    always_ff @(posedge clk) begin
        if (accept) ws <= ms_pl;
    end

    // The instruction alongside a flush, and any during FLUSH, never becomes valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            state    <= RUN;
            cnt      <= '0;
        end else begin
            ws_valid <= accept && (state == RUN) && !flush_req;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RUN: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    wb_ex_prio u_prio (
        .has_int  (ws_valid & has_int),
        .ex_adef  (ws.ex_adef),
        .ex_ine   (ws.ex_ine),
        .ex_sys   (ws.ex_sys),
        .ex_brk   (ws.ex_brk),
        .ex_ale   (ws.ex_ale),
        .ex_valid (ex_valid),
        .ecode    (ex_code),
        .esubcode (ex_sub)
    );

    assign wb_ex       = ws_valid & ex_valid;
    assign wb_ecode    = wb_ex ? ex_code : '0;
    assign wb_esubcode = wb_ex ? ex_sub : '0;
    assign wb_pc       = wb_ex ? ws.pc : '0;
    assign wb_vaddr    = wb_ex ? ws.vaddr : '0;
    assign ertn_flush  = ws_valid & ws.ertn & ~wb_ex;
    assign commit      = ws_valid & ~wb_ex;

    // Payload is not reset, so data outputs are masked by their enables.
    assign rf_we      = commit & ws.rf_we;
    assign rf_waddr   = rf_we ? ws.rf_waddr : '0;
    assign rf_wdata   = rf_we ? ws.rf_wdata : '0;
    assign csr_we     = commit & ws.csr_we;
    assign csr_num    = csr_we ? ws.csr_num : '0;
    assign csr_wmask  = csr_we ? ws.csr_wmask : '0;
    assign csr_wvalue = csr_we ? ws.csr_wvalue : '0;

    assign flush_req    = wb_ex | ertn_flush;
    assign flush_target = wb_ex      ? csr_eentry :
                          ertn_flush ? csr_era    : '0;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = ws_valid ? ws.pc : '0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed scoreboard bench for wb_commit (FLUSH_CYCLES=2).
module tb_wb_commit;

    localparam logic [31:0] EENTRY = 32'h1c00_8000;
    localparam logic [31:0] ERA    = 32'h1c00_0100;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex;
        logic [5:0]  ecode;
        logic        ertn;
        logic        flush;
        logic [31:0] target;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [31:0] pc;
        logic [31:0] vaddr;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_vaddr;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_ex_adef;
    logic        ms_ex_ine;
    logic        ms_ex_sys;
    logic        ms_ex_brk;
    logic        ms_ex_ale;
    logic        ms_ertn;
    logic        ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask;
    logic [31:0] ms_csr_wvalue;
    logic        has_int;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush_req;
    logic [31:0] flush_target;

    int   checks;
    int   failures;
    exp_t sb[$];

    wb_commit #(.FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ms_valid      (ms_valid),
        .ws_allowin    (ws_allowin),
        .ms_pc         (ms_pc),
        .ms_vaddr      (ms_vaddr),
        .ms_rf_we      (ms_rf_we),
        .ms_rf_waddr   (ms_rf_waddr),
        .ms_rf_wdata   (ms_rf_wdata),
        .ms_ex_adef    (ms_ex_adef),
        .ms_ex_ine     (ms_ex_ine),
        .ms_ex_sys     (ms_ex_sys),
        .ms_ex_brk     (ms_ex_brk),
        .ms_ex_ale     (ms_ex_ale),
        .ms_ertn       (ms_ertn),
        .ms_csr_we     (ms_csr_we),
        .ms_csr_num    (ms_csr_num),
        .ms_csr_wmask  (ms_csr_wmask),
        .ms_csr_wvalue (ms_csr_wvalue),
        .has_int       (has_int),
        .csr_eentry    (csr_eentry),
        .csr_era       (csr_era),
        .wb_ex         (wb_ex),
        .wb_ecode      (wb_ecode),
        .wb_esubcode   (wb_esubcode),
        .wb_pc         (wb_pc),
        .wb_vaddr      (wb_vaddr),
        .ertn_flush    (ertn_flush),
        .csr_we        (csr_we),
        .csr_num       (csr_num),
        .csr_wmask     (csr_wmask),
        .csr_wvalue    (csr_wvalue),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .flush_req     (flush_req),
        .flush_target  (flush_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ms();
        ms_valid      = 1'b0;
        ms_pc         = '0;
        ms_vaddr      = '0;
        ms_rf_we      = 1'b0;
        ms_rf_waddr   = '0;
        ms_rf_wdata   = '0;
        ms_ex_adef    = 1'b0;
        ms_ex_ine     = 1'b0;
        ms_ex_sys     = 1'b0;
        ms_ex_brk     = 1'b0;
        ms_ex_ale     = 1'b0;
        ms_ertn       = 1'b0;
        ms_csr_we     = 1'b0;
        ms_csr_num    = '0;
        ms_csr_wmask  = '0;
        ms_csr_wvalue = '0;
    endtask

    // flags = {adef, ine, sys, brk, ale}; hi is has_int during the WB cycle
    task automatic drive(input logic [31:0] pc,
                         input logic        we,
                         input logic [4:0]  waddr,
                         input logic [31:0] wdata,
                         input logic [4:0]  flags,
                         input logic        ertn,
                         input logic        cwe,
                         input logic        hi,
                         input logic        discard);
        exp_t e;
        logic ex;
        ms_valid      = 1'b1;
        ms_pc         = pc;
        ms_vaddr      = pc ^ 32'h0000_00ff;
        ms_rf_we      = we;
        ms_rf_waddr   = waddr;
        ms_rf_wdata   = wdata;
        ms_ex_adef    = flags[4];
        ms_ex_ine     = flags[3];
        ms_ex_sys     = flags[2];
        ms_ex_brk     = flags[1];
        ms_ex_ale     = flags[0];
        ms_ertn       = ertn;
        ms_csr_we     = cwe;
        ms_csr_num    = pc[13:0];
        ms_csr_wmask  = 32'hffff_0000;
        ms_csr_wvalue = wdata ^ 32'h5a5a_5a5a;
        has_int       = hi;
        e = '0;
        if (!discard) begin
            ex = hi | (|flags);
            e.ex = ex;
            if (hi)            e.ecode = 6'h00;
            else if (flags[4]) e.ecode = 6'h08;
            else if (flags[3]) e.ecode = 6'h0d;
            else if (flags[2]) e.ecode = 6'h0b;
            else if (flags[1]) e.ecode = 6'h0c;
            else if (flags[0]) e.ecode = 6'h09;
            e.ertn   = ertn & ~ex;
            e.flush  = ex | e.ertn;
            e.target = ex ? EENTRY : (e.ertn ? ERA : 32'h0);
            e.rf_we  = we & ~ex;
            if (e.rf_we) begin
                e.waddr = waddr;
                e.wdata = wdata;
            end
            e.csr_we = cwe & ~ex;
            if (e.csr_we) begin
                e.csr_num    = pc[13:0];
                e.csr_wmask  = 32'hffff_0000;
                e.csr_wvalue = wdata ^ 32'h5a5a_5a5a;
            end
            if (ex) begin
                e.pc    = pc;
                e.vaddr = pc ^ 32'h0000_00ff;
            end
        end
        sb.push_back(e);
    endtask

    task automatic check_outputs(input exp_t e);
        chk("ws_allowin", 32'(ws_allowin), 32'd1);
        chk("rf_we", 32'(rf_we), 32'(e.rf_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
        chk("rf_wdata", rf_wdata, e.wdata);
        chk("wb_ex", 32'(wb_ex), 32'(e.ex));
        chk("wb_ecode", 32'(wb_ecode), 32'(e.ecode));
        chk("wb_esubcode", 32'(wb_esubcode), 32'd0);
        chk("ertn_flush", 32'(ertn_flush), 32'(e.ertn));
        chk("flush_req", 32'(flush_req), 32'(e.flush));
        chk("flush_target", flush_target, e.target);
        chk("csr_we", 32'(csr_we), 32'(e.csr_we));
        chk("csr_num", 32'(csr_num), 32'(e.csr_num));
        chk("csr_wmask", csr_wmask, e.csr_wmask);
        chk("csr_wvalue", csr_wvalue, e.csr_wvalue);
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_vaddr", wb_vaddr, e.vaddr);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        clear_ms();
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        check_outputs(e);
        has_int = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        csr_eentry = EENTRY;
        csr_era    = ERA;
        has_int    = 1'b0;
        clear_ms();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs('0);
        @(negedge clk);
        resetn = 1'b1;

        // plain register write
        drive(32'h1c00_0010, 1'b1, 5'd5, 32'h1234, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        // CSR write
        drive(32'h1c00_0014, 1'b0, 5'd0, 32'h0abc, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        // back-to-back commits
        drive(32'h1c00_0018, 1'b1, 5'd31, 32'hdead_beef, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h1c00_001c, 1'b1, 5'd1, 32'h0000_0001, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // sys + ale: sys wins; instruction alongside flush_req discarded
        drive(32'h1c00_0020, 1'b1, 5'd6, 32'h55, 5'b00101, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h1c00_0024, 1'b1, 5'd7, 32'h66, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();

        // interrupt over brk
        drive(32'h1c00_0040, 1'b1, 5'd8, 32'h77, 5'b00010, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        repeat (3) tick();

        // ertn: two instructions in the FLUSH window dropped, third commits
        drive(32'h1c00_0050, 1'b0, 5'd0, 32'h0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(32'h1c00_0054, 1'b1, 5'd9, 32'h91, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'h1c00_0058, 1'b1, 5'd10, 32'h92, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'h1c00_005c, 1'b1, 5'd11, 32'h93, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // ertn with ine: exception overrides ertn
        drive(32'h1c00_0060, 1'b1, 5'd12, 32'ha0, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        repeat (3) tick();

        // each single exception flag, then a mixed set
        for (int i = 0; i < 5; i++) begin
            drive(32'h1c00_0100 + 32'(i * 4), 1'b1, 5'(i + 2), 32'(i),
                  5'(1 << i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            repeat (3) tick();
        end
        drive(32'h1c00_0200, 1'b1, 5'd3, 32'h3, 5'b11010, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        repeat (3) tick();

        // reset one cycle into FLUSH aborts the flush
        drive(32'h1c00_0300, 1'b1, 5'd4, 32'h4, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check_outputs('0);
        @(negedge clk);
        resetn = 1'b1;
        drive(32'h1c00_0304, 1'b1, 5'd13, 32'h0000_cafe, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
